// File: rtl/turbo_pkg.sv
// Shared types and elaboration helpers for the turbo decoder alpha path.
package turbo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } alpha_fsm_t;

    // Most negative metric used for unreachable states; finite so later adds never produce inf/NaN.
    function automatic logic [31:0] neg_big(input bit is_single);
        return is_single ? 32'hC700_0000 : 32'h0000_F800;
    endfunction

    function automatic int exp_width(input bit is_single);
        return is_single ? 8 : 5;
    endfunction

    function automatic int step_w(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/alpha_ram.sv
// Simple dual-port alpha store: one write port, one registered read port returning old data on collision.
module alpha_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 65,
    parameter int AW    = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Addresses past the last step read as zero rather than aliasing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_re) r_rdata <= (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/float_math_if.sv
// Combinational IEEE-754 adder (round to nearest even) for HALF or SINGLE words.
module float_math_if
    import turbo_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_sum
);
    localparam int              EW     = exp_width(PRECISION == "SINGLE");
    localparam int              MW     = BITS - 1 - EW;
    localparam int              W      = MW + 4;
    localparam logic [EW-1:0]   EMAX   = '1;
    localparam logic [EW-1:0]   EF_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW+1:0]   E_ONE  = {{(EW+1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0] QNAN   = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

    logic            w_swap;
    logic            w_sl, w_ss;
    logic [EW-1:0]   w_el, w_es, w_d;
    logic [MW-1:0]   w_ml, w_ms, w_mant;
    logic [W-1:0]    w_fl, w_fs, w_al;
    logic            w_st, w_inc, w_hid;
    logic [W:0]      w_sum;
    logic [EW+1:0]   w_e;
    logic [MW+1:0]   w_rnd;
    logic [BITS-1:0] w_res;

    always_comb begin
        w_swap = i_b[BITS-2:0] > i_a[BITS-2:0];
        {w_sl, w_el, w_ml} = w_swap ? i_b : i_a;
        {w_ss, w_es, w_ms} = w_swap ? i_a : i_b;
        w_fl = {(w_el != '0), w_ml, 3'b000};
        w_fs = {(w_es != '0), w_ms, 3'b000};
        // Subnormals share the minimum normal exponent; the hidden bit above carries the difference.
        w_d  = ((w_el == '0) ? EF_ONE : w_el) - ((w_es == '0) ? EF_ONE : w_es);
        w_e  = {2'b00, ((w_el == '0) ? EF_ONE : w_el)};

        w_st = 1'b0;
        for (int unsigned i = 0; i < W; i++)
            if (i < 32'(w_d)) w_st = w_st | w_fs[i];
        w_al    = (32'(w_d) >= W) ? '0 : (w_fs >> w_d);
        w_al[0] = w_al[0] | w_st;

        if (w_sl == w_ss) w_sum = {1'b0, w_fl} + {1'b0, w_al};
        else              w_sum = {1'b0, w_fl} - {1'b0, w_al};

        if (w_sum[W]) begin
            w_sum = {1'b0, w_sum[W:2], w_sum[1] | w_sum[0]};
            w_e   = w_e + E_ONE;
        end else begin
            for (int unsigned i = 0; i < W; i++)
                if (!w_sum[W-1] && w_e > E_ONE) begin
                    w_sum = w_sum << 1;
                    w_e   = w_e - E_ONE;
                end
        end

        w_inc = w_sum[2] & (w_sum[1] | w_sum[0] | w_sum[3]);
        w_rnd = {1'b0, w_sum[W-1:3]} + {{(MW+1){1'b0}}, w_inc};
        if (w_rnd[MW+1]) begin
            w_e    = w_e + E_ONE;
            w_mant = '0;
            w_hid  = 1'b1;
        end else begin
            w_mant = w_rnd[MW-1:0];
            w_hid  = w_rnd[MW];
        end

        if (w_sum == '0)               w_res = {w_sl & w_ss, {(BITS-1){1'b0}}};
        else if (w_e >= {2'b00, EMAX}) w_res = {w_sl, EMAX, {MW{1'b0}}};
        else if (!w_hid)               w_res = {w_sl, {EW{1'b0}}, w_mant};
        else                           w_res = {w_sl, w_e[EW-1:0], w_mant};

        if (i_a[BITS-2 -: EW] == EMAX && i_b[BITS-2 -: EW] == EMAX)
            w_res = (i_a == i_b) ? i_a : QNAN;
        else if (i_a[BITS-2 -: EW] == EMAX)
            w_res = i_a;
        else if (i_b[BITS-2 -: EW] == EMAX)
            w_res = i_b;
    end

    assign o_sum = w_res;

endmodule

// File: rtl/alpha_normalize_buffer.sv
// Normalizes each step's alpha vector against state 0, feeds it back as previousAlpha and stores it per step.
module alpha_normalize_buffer
    import turbo_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    STATES    = 8,
    parameter int    BLOCK_LEN = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [STATES-1:0][BITS-1:0]    alpha_in,
    output logic                           fb_valid,
    output logic [STATES-1:0][BITS-1:0]    alpha_fb,
    output logic                           busy,
    output logic                           frame_done,
    input  logic                           rd_en,
    input  logic [$clog2(BLOCK_LEN+1)-1:0] rd_addr,
    output logic                           rd_valid,
    output logic [STATES-1:0][BITS-1:0]    rd_data
);
    typedef logic [STATES-1:0][BITS-1:0] alpha_vec_t;

    localparam bit                IS_SINGLE = (PRECISION == "SINGLE");
    localparam int                STEP_W    = step_w(BLOCK_LEN);
    localparam logic [BITS-1:0]   NEG_BIG   = BITS'(neg_big(IS_SINGLE));
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BLOCK_LEN);

    alpha_fsm_t        r_state;
    logic [STEP_W-1:0] r_step;
    logic              r_fb_valid, r_busy, r_frame_done, r_rd_valid;
    alpha_vec_t        r_alpha_fb;

    alpha_vec_t        w_norm, w_init_vec, w_wdata;
    logic [BITS-1:0]   w_neg_ref;
    logic              w_we;
    logic [STEP_W-1:0] w_waddr;

    assign w_neg_ref = {~alpha_in[0][BITS-1], alpha_in[0][BITS-2:0]};

    for (genvar s = 0; s < STATES; s++) begin : g_norm
        float_math_if #(
            .BITS      (BITS),
            .PRECISION (PRECISION)
        ) u_float_math (
            .i_a   (alpha_in[s]),
            .i_b   (w_neg_ref),
            .o_sum (w_norm[s])
        );
    end

    always_comb begin
        for (int unsigned s = 0; s < STATES; s++)
            w_init_vec[s] = (s == 0) ? '0 : NEG_BIG;
    end

    // A start in RUN takes priority over a coincident in_valid, so an aborted step is never stored.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = w_norm;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_wdata = w_init_vec;
        end else if (r_state == ST_RUN && in_valid && !start) begin
            w_we    = 1'b1;
            w_waddr = r_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_fb_valid   <= 1'b0;
            r_alpha_fb   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_fb_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    r_alpha_fb <= w_init_vec;
                    r_fb_valid <= 1'b1;
                    r_step     <= STEP_ONE;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (start) begin
                        r_state <= ST_INIT;
                    end else if (in_valid) begin
                        r_alpha_fb <= w_norm;
                        r_fb_valid <= 1'b1;
                        if (r_step == STEP_LAST) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_step <= r_step + STEP_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_valid <= 1'b0;
        else        r_rd_valid <= rd_en;
    end

    alpha_ram #(
        .WIDTH (BITS * STATES),
        .DEPTH (BLOCK_LEN + 1),
        .AW    (STEP_W)
    ) u_alpha_ram (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (rd_en),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign fb_valid   = r_fb_valid;
    assign alpha_fb   = r_alpha_fb;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_alpha_normalize_buffer.sv
// Randomized self-checking bench for alpha_normalize_buffer (HALF, 4 states, 4-step frames).
`timescale 1ns/1ps
module tb_alpha_normalize_buffer;
    localparam int BITS      = 16;
    localparam int STATES    = 4;
    localparam int BLOCK_LEN = 4;
    localparam int AW        = 3;

    typedef logic [STATES-1:0][BITS-1:0] vec_t;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic            start    = 1'b0;
    logic            in_valid = 1'b0;
    logic            rd_en    = 1'b0;
    logic [AW-1:0]   rd_addr  = '0;
    vec_t            alpha_in = '0;
    logic            fb_valid, busy, frame_done, rd_valid;
    vec_t            alpha_fb, rd_data;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t exp_mem [BLOCK_LEN+1];
    vec_t init_vec;

    alpha_normalize_buffer #(
        .BITS      (BITS),
        .PRECISION ("HALF"),
        .STATES    (STATES),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .alpha_in   (alpha_in),
        .fb_valid   (fb_valid),
        .alpha_fb   (alpha_fb),
        .busy       (busy),
        .frame_done (frame_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Exact real -> half conversion; stimulus keeps every value and difference exactly representable.
    function automatic logic [15:0] r2h(input real v);
        real  a;
        int   e;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        return {s, 5'(e + 15), 10'(int'((a - 1.0) * 1024.0))};
    endfunction

    task automatic make_step(output vec_t v, output vec_t n);
        int k [STATES];
        for (int s = 0; s < STATES; s++) k[s] = int'($urandom_range(2000)) - 1000;
        if ($urandom_range(3) == 0) k[1 + $urandom_range(STATES-2)] = k[0];
        for (int s = 0; s < STATES; s++) begin
            v[s] = r2h(real'(k[s]) / 4.0);
            n[s] = r2h(real'(k[s] - k[0]) / 4.0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output vec_t d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        d       = rd_data;
        v       = rd_valid;
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            alpha_in = {$urandom, $urandom};
            rd_en    = 1'($urandom);
            rd_addr  = 3'($urandom);
            tick();
            n_total++;
            if ({fb_valid, busy, frame_done, rd_valid} !== 4'b0000 || alpha_fb !== '0 || rd_data !== '0)
                $display("FAIL reset_outputs: got fb=%b busy=%b done=%b rdv=%b fb=%h rd=%h, want all 0",
                         fb_valid, busy, frame_done, rd_valid, alpha_fb, rd_data);
            else n_pass++;
        end
        start    = 1'b0;
        rd_en    = 1'b0;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alpha_in = {$urandom, $urandom};
            tick();
            n_total++;
            if (fb_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_ignores_in_valid: got fb_valid=%b busy=%b, want 0 0", fb_valid, busy);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_init();
        vec_t d;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || fb_valid !== 1'b0)
            $display("FAIL init_cycle: got busy=%b fb_valid=%b, want 1 0", busy, fb_valid);
        else n_pass++;
        tick();
        n_total++;
        if (fb_valid !== 1'b1 || alpha_fb !== init_vec)
            $display("FAIL init_vector: got fb_valid=%b alpha_fb=%h, want 1 %h", fb_valid, alpha_fb, init_vec);
        else n_pass++;
        exp_mem[0] = init_vec;
        do_read(3'd0, d, v);
        n_total++;
        if (v !== 1'b1 || d !== init_vec)
            $display("FAIL read_init: got rd_valid=%b rd_data=%h, want 1 %h", v, d, init_vec);
        else n_pass++;
        n_total++;
        if (fb_valid !== 1'b0)
            $display("FAIL fb_valid_pulse: got fb_valid=%b, want 0", fb_valid);
        else n_pass++;
    endtask

    task automatic test_run_directed();
        vec_t d, e;
        logic v;
        alpha_in[0] = 16'h4000; alpha_in[1] = 16'h4200; alpha_in[2] = 16'h3C00; alpha_in[3] = 16'h4000;
        e[0] = 16'h0000; e[1] = 16'h3C00; e[2] = 16'hBC00; e[3] = 16'h0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (fb_valid !== 1'b1 || alpha_fb !== e)
            $display("FAIL run_directed: got fb_valid=%b alpha_fb=%h, want 1 %h", fb_valid, alpha_fb, e);
        else n_pass++;
        exp_mem[1] = e;
        do_read(3'd1, d, v);
        n_total++;
        if (v !== 1'b1 || d !== e)
            $display("FAIL read_step1: got rd_valid=%b rd_data=%h, want 1 %h", v, d, e);
        else n_pass++;
        n_total++;
        if (alpha_fb !== e)
            $display("FAIL fb_hold: got alpha_fb=%h, want %h", alpha_fb, e);
        else n_pass++;
        tick();
        n_total++;
        if (rd_valid !== 1'b0 || rd_data !== e)
            $display("FAIL read_hold: got rd_valid=%b rd_data=%h, want 0 %h", rd_valid, rd_data, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        vec_t v, n, last_n, d, e;
        logic rv;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_mem[0] = init_vec;
        last_n = '0;
        in_valid = 1'b1;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            make_step(v, n);
            alpha_in = v;
            tick();
            n_total++;
            if (fb_valid !== 1'b1 || alpha_fb !== n)
                $display("FAIL b2b_data[%0d]: got fb_valid=%b alpha_fb=%h, want 1 %h", i, fb_valid, alpha_fb, n);
            else n_pass++;
            n_total++;
            if (frame_done !== (i == BLOCK_LEN-1) || busy !== (i != BLOCK_LEN-1))
                $display("FAIL b2b_status[%0d]: got frame_done=%b busy=%b, want %b %b",
                         i, frame_done, busy, i == BLOCK_LEN-1, i != BLOCK_LEN-1);
            else n_pass++;
            exp_mem[i+1] = n;
            last_n = n;
        end
        make_step(v, n);
        alpha_in = v;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (fb_valid !== 1'b0 || frame_done !== 1'b0 || alpha_fb !== last_n)
            $display("FAIL done_ignores_in_valid: got fb_valid=%b frame_done=%b alpha_fb=%h, want 0 0 %h",
                     fb_valid, frame_done, alpha_fb, last_n);
        else n_pass++;
        for (int a = 0; a < 8; a++) begin
            e = (a <= BLOCK_LEN) ? exp_mem[a] : '0;
            do_read(3'(a), d, rv);
            n_total++;
            if (rv !== 1'b1 || d !== e)
                $display("FAIL b2b_read[%0d]: got rd_valid=%b rd_data=%h, want 1 %h", a, rv, d, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midrun();
        vec_t v, n, d;
        logic rv;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rd_en = 1'b1;
        rd_addr = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            make_step(v, n);
            alpha_in = v;
            tick();
        end
        in_valid = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({fb_valid, busy, frame_done, rd_valid} !== 4'b0000 || alpha_fb !== '0 || rd_data !== '0)
            $display("FAIL midrun_reset: got fb=%b busy=%b done=%b rdv=%b fb=%h rd=%h, want all 0",
                     fb_valid, busy, frame_done, rd_valid, alpha_fb, rd_data);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_total++;
        if (fb_valid !== 1'b1 || alpha_fb !== init_vec)
            $display("FAIL restart_init: got fb_valid=%b alpha_fb=%h, want 1 %h", fb_valid, alpha_fb, init_vec);
        else n_pass++;
        exp_mem[0] = init_vec;
        in_valid = 1'b1;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            make_step(v, n);
            alpha_in = v;
            tick();
            n_total++;
            if (fb_valid !== 1'b1 || alpha_fb !== n || frame_done !== (i == BLOCK_LEN-1))
                $display("FAIL restart_step[%0d]: got fb_valid=%b alpha_fb=%h frame_done=%b, want 1 %h %b",
                         i, fb_valid, alpha_fb, frame_done, n, i == BLOCK_LEN-1);
            else n_pass++;
            exp_mem[i+1] = n;
        end
        in_valid = 1'b0;
        for (int a = 1; a <= BLOCK_LEN; a++) begin
            do_read(3'(a), d, rv);
            n_total++;
            if (rv !== 1'b1 || d !== exp_mem[a])
                $display("FAIL restart_read[%0d]: got rd_valid=%b rd_data=%h, want 1 %h", a, rv, d, exp_mem[a]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        vec_t v, n, d;
        logic rv;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_mem[0] = init_vec;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            make_step(v, n);
            alpha_in = v;
            tick();
            n_total++;
            if (fb_valid !== 1'b1 || alpha_fb !== n)
                $display("FAIL abort_pre_step[%0d]: got fb_valid=%b alpha_fb=%h, want 1 %h", i, fb_valid, alpha_fb, n);
            else n_pass++;
            exp_mem[i+1] = n;
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (fb_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL abort_gap: got fb_valid=%b busy=%b, want 0 1", fb_valid, busy);
        else n_pass++;
        tick();
        n_total++;
        if (fb_valid !== 1'b1 || alpha_fb !== init_vec)
            $display("FAIL abort_init: got fb_valid=%b alpha_fb=%h, want 1 %h", fb_valid, alpha_fb, init_vec);
        else n_pass++;
        make_step(v, n);
        alpha_in = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (fb_valid !== 1'b1 || alpha_fb !== n || busy !== 1'b1)
            $display("FAIL abort_step1: got fb_valid=%b alpha_fb=%h busy=%b, want 1 %h 1", fb_valid, alpha_fb, busy, n);
        else n_pass++;
        exp_mem[1] = n;
        for (int a = 1; a <= 3; a++) begin
            do_read(3'(a), d, rv);
            n_total++;
            if (rv !== 1'b1 || d !== exp_mem[a])
                $display("FAIL abort_read[%0d]: got rd_valid=%b rd_data=%h, want 1 %h", a, rv, d, exp_mem[a]);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        init_vec[0] = 16'h0000;
        for (int s = 1; s < STATES; s++) init_vec[s] = 16'hF800;
        test_reset();
        test_start_init();
        test_run_directed();
        test_back_to_back();
        test_reset_midrun();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
